// File: rtl/audio_pkg.sv
// Shared audio-chain definitions: sample width and serializer state encodings.
// Imported by the filter stages and the DAC serializer.
package audio_pkg;

   localparam int AUDIO_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_PAD
   } ser_state_t;

endpackage

// File: rtl/lrck_edge_detect.sv
// LRCK edge detector: registers the frame clock and flags rise/fall.
// Ports: AUD_BCLK, reset (async, low) / lrck in; lrck_d, rise, fall out.
module lrck_edge_detect (
   input  logic AUD_BCLK,
   input  logic reset,
   input  logic lrck,
   output logic lrck_d,
   output logic rise,
   output logic fall
);

   always_ff @(posedge AUD_BCLK or negedge reset) begin
      if (!reset) lrck_d <= 1'b0;
      else        lrck_d <= lrck;
   end

   // Combinational pulses, valid in the cycle the new level is first seen.
   assign rise = lrck & ~lrck_d;
   assign fall = ~lrck & lrck_d;

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: latches a coherent L/R pair on each LRCK fall and
// shifts WORD_BITS bits MSB-first onto AUD_DACDAT, zero-padded to frame end.
// Ports: AUD_BCLK, reset (async, low), AUD_DACLRCK, left/right samples,
// mute in; AUD_DACDAT, sample_strobe, frame_error (sticky) out.
module audio_dac_serializer
   import audio_pkg::*;
#(
   parameter int WORD_BITS = 32
) (
   input  logic                   AUD_BCLK,
   input  logic                   reset,
   input  logic                   AUD_DACLRCK,
   input  logic [AUDIO_WIDTH-1:0] left_channel_audio_in,
   input  logic [AUDIO_WIDTH-1:0] right_channel_audio_in,
   input  logic                   mute,
   output logic                   AUD_DACDAT,
   output logic                   sample_strobe,
   output logic                   frame_error
);

   localparam logic [4:0] LAST = 5'(WORD_BITS - 1);

   ser_state_t             state;
   logic [AUDIO_WIDTH-1:0] hold_l;
   logic [AUDIO_WIDTH-1:0] hold_r;
   logic [AUDIO_WIDTH-1:0] sreg;
   logic [4:0]             cnt;

   logic lrck_d;
   logic rise;
   logic fall;
   logic lr_edge;
   logic do_load;

   logic [AUDIO_WIDTH-1:0] new_l;
   logic [AUDIO_WIDTH-1:0] new_r;
   logic [AUDIO_WIDTH-1:0] load_word;

   lrck_edge_detect u_edge (
      .AUD_BCLK (AUD_BCLK),
      .reset    (reset),
      .lrck     (AUD_DACLRCK),
      .lrck_d   (lrck_d),
      .rise     (rise),
      .fall     (fall)
   );

   assign lr_edge = AUD_DACLRCK ^ lrck_d;

   assign new_l = mute ? '0 : left_channel_audio_in;
   assign new_r = mute ? '0 : right_channel_audio_in;

   // Left word comes straight from the inputs so its MSB goes out this
   // cycle; right word always comes from the pair latched at the fall.
   assign load_word = fall ? new_l : hold_r;

   // IDLE only starts on a fall so the first word is always a left word.
   assign do_load = fall | (lr_edge & (state != ST_IDLE));

   always_ff @(posedge AUD_BCLK or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         hold_l        <= '0;
         hold_r        <= '0;
         sreg          <= '0;
         cnt           <= '0;
         AUD_DACDAT    <= 1'b0;
         sample_strobe <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         sample_strobe <= fall;
         if (fall) begin
            hold_l <= new_l;
            hold_r <= new_r;
         end
         if (do_load) begin
            // Edge while the last bit is on the wire is a complete word.
            if (state == ST_SHIFT && cnt != LAST) frame_error <= 1'b1;
            AUD_DACDAT <= load_word[AUDIO_WIDTH-1];
            sreg       <= {load_word[AUDIO_WIDTH-2:0], 1'b0};
            cnt        <= '0;
            state      <= ST_SHIFT;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  AUD_DACDAT <= 1'b0;
               end
               ST_SHIFT: begin
                  if (cnt == LAST) begin
                     AUD_DACDAT <= 1'b0;
                     state      <= ST_PAD;
                  end else begin
                     AUD_DACDAT <= sreg[AUDIO_WIDTH-1];
                     sreg       <= {sreg[AUDIO_WIDTH-2:0], 1'b0};
                     cnt        <= cnt + 5'd1;
                  end
               end
               ST_PAD: begin
                  AUD_DACDAT <= 1'b0;
               end
               default: begin
                  AUD_DACDAT <= 1'b0;
                  state      <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer at WORD_BITS=32 and 24.
// Both instances share stimulus; serial words are captured and compared.
module tb_audio_dac_serializer;

   logic        clk;
   logic        rst_n;
   logic        lrck;
   logic [31:0] left;
   logic [31:0] right;
   logic        mute;
   logic        dat32, stb32, ferr32;
   logic        dat24, stb24, ferr24;

   int tests = 0;
   int fails = 0;

   audio_dac_serializer dut32 (
      .AUD_BCLK               (clk),
      .reset                  (rst_n),
      .AUD_DACLRCK            (lrck),
      .left_channel_audio_in  (left),
      .right_channel_audio_in (right),
      .mute                   (mute),
      .AUD_DACDAT             (dat32),
      .sample_strobe          (stb32),
      .frame_error            (ferr32)
   );

   audio_dac_serializer #(.WORD_BITS(24)) dut24 (
      .AUD_BCLK               (clk),
      .reset                  (rst_n),
      .AUD_DACLRCK            (lrck),
      .left_channel_audio_in  (left),
      .right_channel_audio_in (right),
      .mute                   (mute),
      .AUD_DACDAT             (dat24),
      .sample_strobe          (stb24),
      .frame_error            (ferr24)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] topmask(input int n);
      logic [31:0] ones;
      ones = '1;
      return (n == 0) ? 32'h0 : (ones << (32 - n));
   endfunction

   // One half-frame of len BCLKs at level lr; captures both serial words.
   task automatic half(input logic lr, input int len, input logic [31:0] w,
                       input int stb, input string tag);
      logic [31:0] g32, g24;
      logic p32, p24;
      int s32, s24, n32, n24;
      g32 = '0; g24 = '0; p32 = 0; p24 = 0; s32 = 0; s24 = 0;
      n32 = (len < 32) ? len : 32;
      n24 = (len < 24) ? len : 24;
      @(negedge clk);
      lrck = lr;
      for (int k = 0; k < len; k++) begin
         @(posedge clk);
         #1;
         if (k < n32) g32[31-k] = dat32;
         else         p32 = p32 | dat32;
         if (k < n24) g24[31-k] = dat24;
         else         p24 = p24 | dat24;
         s32 += int'(stb32);
         s24 += int'(stb24);
      end
      chk({tag, "_w32"}, g32, w & topmask(n32));
      chk({tag, "_w24"}, g24, w & topmask(n24));
      chk({tag, "_pad32"}, 32'(p32), 32'h0);
      chk({tag, "_pad24"}, 32'(p24), 32'h0);
      chk({tag, "_stb32"}, 32'(s32), 32'(stb));
      chk({tag, "_stb24"}, 32'(s24), 32'(stb));
   endtask

   initial begin
      rst_n = 1'b0;
      lrck  = 1'b0;
      left  = 32'hA5A5_0001;
      right = 32'h8000_0000;
      mute  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dat32", 32'(dat32), 32'h0);
      chk("rst_stb32", 32'(stb32), 32'h0);
      chk("rst_err32", 32'(ferr32), 32'h0);
      chk("rst_dat24", 32'(dat24), 32'h0);
      chk("rst_err24", 32'(ferr24), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      half(1'b1, 32, 32'h0, 0, "idle_rise");
      half(1'b0, 32, 32'hA5A5_0001, 1, "l1");
      half(1'b1, 32, 32'h8000_0000, 0, "r1");

      half(1'b0, 32, 32'hA5A5_0001, 1, "l2");
      right = 32'h1234_5678;
      half(1'b1, 32, 32'h8000_0000, 0, "r2_tear");
      half(1'b0, 32, 32'hA5A5_0001, 1, "l3");
      half(1'b1, 32, 32'h1234_5678, 0, "r3");

      mute = 1'b1;
      half(1'b0, 32, 32'h0, 1, "l_mute");
      half(1'b1, 32, 32'h0, 0, "r_mute");
      mute = 1'b0;
      left = 32'hFFFF_FF00;
      half(1'b0, 32, 32'hFFFF_FF00, 1, "l4");
      half(1'b1, 32, 32'h1234_5678, 0, "r4");
      chk("noerr32", 32'(ferr32), 32'h0);
      chk("noerr24", 32'(ferr24), 32'h0);

      half(1'b0, 20, 32'hFFFF_FF00, 1, "l_short");
      half(1'b1, 32, 32'h1234_5678, 0, "r_after_short");
      chk("short_err32", 32'(ferr32), 32'h1);
      chk("short_err24", 32'(ferr24), 32'h1);
      left = 32'hA5A5_0001;
      half(1'b0, 32, 32'hA5A5_0001, 1, "l5");
      half(1'b1, 32, 32'h1234_5678, 0, "r5");
      chk("sticky_err32", 32'(ferr32), 32'h1);

      @(negedge clk);
      lrck = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_dat32", 32'(dat32), 32'h0);
      chk("midrst_err32", 32'(ferr32), 32'h0);
      chk("midrst_err24", 32'(ferr24), 32'h0);
      chk("midrst_stb32", 32'(stb32), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      half(1'b1, 32, 32'h0, 0, "post_rst_rise");
      half(1'b0, 32, 32'hA5A5_0001, 1, "resume_l");
      half(1'b1, 32, 32'h1234_5678, 0, "resume_r");

      @(negedge clk);
      rst_n = 1'b0;
      lrck  = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      half(1'b1, 32, 32'h0, 0, "startup_rise");
      half(1'b0, 32, 32'hA5A5_0001, 1, "startup_l");
      half(1'b1, 32, 32'h1234_5678, 0, "startup_r");
      chk("final_err32", 32'(ferr32), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Downstream stage of the audio filter chain. Takes the parallel 32-bit left/right samples produced by the filter stage and shifts them MSB-first onto the codec DAC data line in I2S format, framed by the codec-supplied AUD_DACLRCK. Latches both channels as one coherent pair at the start of each left frame, so filter history updates during the right half-frame cannot tear a sample pair.

## Interface
- WORD_BITS, 32: bits shifted per channel (1..32). The top WORD_BITS bits of each 32-bit input are sent; lower bits are dropped.
- AUD_BCLK  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- AUD_DACLRCK  in  1  codec frame clock, synchronous to AUD_BCLK. 0 = left frame, 1 = right frame.
- left_channel_audio_in  in  32  left sample from the filter stage, two's complement.
- right_channel_audio_in  in  32  right sample from the filter stage, two's complement.
- mute  in  1  when 1 at latch time, the latched pair is forced to zero.
- AUD_DACDAT  out  1  serial DAC data. Codec is configured with BCLKINV=1, so it samples on BCLK falling edge.
- sample_strobe  out  1  one-cycle pulse when a new pair is latched.
- frame_error  out  1  sticky flag: a frame was shorter than WORD_BITS bits. Cleared only by reset.

## Operation
- The block registers AUD_DACLRCK into lrck_d. A cycle E is an edge cycle when the sampled AUD_DACLRCK differs from lrck_d.
- Falling edge (1→0):
  - Latch left_channel_audio_in and right_channel_audio_in into hold_l and hold_r. Latch zeros if mute=1.
  - Pulse sample_strobe.
  - Load the shift register with the left word, taken from the live input (or 0 if muted), which equals the value stored in hold_l.
- Rising edge (0→1): load the shift register from hold_r. The live right input is never used at this point.
- State machine:
  - IDLE: entered on reset. AUD_DACDAT=0. Ignores rising edges. Moves to SHIFT on the first falling edge, so the first transmitted word is always a left word.
  - SHIFT: at each posedge, output the current MSB and shift left by one. The bit counter counts 0..WORD_BITS-1. When the count reaches WORD_BITS-1 and no edge is present, move to PAD.
  - PAD: AUD_DACDAT=0 until the next LRCK edge, then reload and return to SHIFT.
- An edge seen while in SHIFT before WORD_BITS bits have been sent (short frame):
  - Abort the current word and set frame_error.
  - Reload per the edge rule above. The new word starts immediately; no bit of the old word follows.
- An edge arriving in the same cycle as the last bit: the edge wins. Reload, and no error is flagged because the word is complete.
- Arithmetic: no arithmetic on sample data. Bits are passed through unchanged. The bit counter is 5 bits wide and must not wrap while in PAD.

## Timing
- Reset values: AUD_DACDAT=0, sample_strobe=0, frame_error=0, state=IDLE, lrck_d=0, hold_l=hold_r=0, counter=0, shift register=0.
- Serial bit order: AUD_DACDAT carries bit (31−k) of the word after posedge E+k, for k=0..WORD_BITS-1.
- I2S delay: the one-cycle edge-detect delay provides the I2S one-BCLK delay. The MSB appears one BCLK after the LRCK transition as seen by the codec.
- sample_strobe is high for exactly the cycle after posedge E of each falling edge, at most once per frame pair.
- Input setup: inputs must be stable at posedge E of the falling edge. Inputs are don't-care at all other times.
- Reset asserted mid-word: outputs go to reset values immediately (asynchronous). After release, the block waits in IDLE for the next falling edge, which gives a clean restart.

## Structure
- Shared package audio_pkg (used by the filter stages as well):
  - AUDIO_WIDTH=32.
  - Serializer state encodings ST_IDLE, ST_SHIFT, ST_PAD.
- Sub-module lrck_edge_detect, also reused by the ADC deserializer:
  - Inputs: AUD_BCLK, reset, lrck.
  - Outputs: lrck_d, rise, fall (combinational pulses).
- Everything else (hold registers, shift register, counter, FSM) lives in the top module.

## Test plan
- Basic left word: reset, then 64-BCLK frames, left=32'hA5A5_0001, right=32'h8000_0000. Required response: after the LRCK fall, DACDAT serialises 1010_0101…0001 on E..E+31. After the rise, it sends 1 followed by 31 zeros. sample_strobe pulses once per 64 cycles.
- Tear-free right channel: change right_channel_audio_in to 32'h1234_5678 while LRCK=0, after the pair latch. Required response: the right word sent is still 32'h8000_0000; the new value goes out on the next frame.
- Mute and word width: WORD_BITS=24, mute=1 for one frame, then 0 with left=32'hFFFF_FF00. Required response: the muted frame is all zeros. The next left frame gives 24 ones then PAD zeros, and frame_error stays 0.
- Short frame: an LRCK edge after 20 of 32 bits. Required response: the new word's MSB appears at E, and frame_error=1 and stays 1.
- Startup alignment: release reset while LRCK=1, then apply a rising edge before any fall. Required response: DACDAT stays 0 and there is no strobe until the first fall.
- Mid-word reset: assert reset at bit 10. Required response: DACDAT=0 and frame_error=0 at once. After release, output resumes only after the next LRCK fall.
